trap_commit: RTL and testbench
==============================

TRAP_COMMIT -- requirements
Module: trap_commit

Interface
REQ-001 SHALL have parameter RESET_MODE, default 2'b11, meaning privilege mode after reset (M).
REQ-002 SHALL have ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- MMU_WAIT  in  1  global stall
- TRAP_EN  in  1  trap request from trap stage
- TRAP_PC  in  32  faulting/interrupted PC
- TRAP_CODE  in  32  mcause value
- TRAP_JMP_TO  in  32  handler address
- CHMODE_DO  in  1  mode change request
- CHMODE_TO  in  2  requested mode
- MRET_EN  in  1  mret retiring
- CSR_W_EN  in  1  software CSR write strobe
- CSR_W_ADDR  in  12  CSR address
- CSR_W_DATA  in  32  CSR write data
- FLUSH  out  1  pipeline flush
- JMP_DO  out  1  fetch redirect strobe
- JMP_PC  out  32  redirect target
- MODE  out  2  current privilege mode
- INT_ALLOW  out  1  mstatus.MIE
- MEPC  out  32  mepc
- MCAUSE  out  32  mcause
- MSTATUS  out  32  mstatus view
- BUSY  out  1  FSM not IDLE

Function
REQ-003 SHALL implement FSM IDLE, REDIRECT, SETTLE; FLUSH, JMP_DO, JMP_PC, BUSY decoded from state/holding registers only, no combinational path from inputs.
REQ-004 IDLE, MMU_WAIT=0, TRAP_EN=1 at cycle N: at end of N mepc<=TRAP_PC & ~3, mcause<=TRAP_CODE, MPIE<=MIE, MIE<=0, MPP<=MODE, MODE<=2'b11, jmp_pc<=TRAP_JMP_TO, state->REDIRECT.
REQ-005 IDLE, MMU_WAIT=0, MRET_EN=1, TRAP_EN=0: MODE<=MPP, MIE<=MPIE, MPIE<=1, MPP<=2'b00, jmp_pc<=mepc, state->REDIRECT.
REQ-006 IDLE, MMU_WAIT=0, CHMODE_DO=1, TRAP_EN=0, MRET_EN=0: MODE<=CHMODE_TO, no state change, no flush.
REQ-007 Priority in same cycle: TRAP_EN > MRET_EN > CHMODE_DO > CSR_W_EN; lower-priority events that cycle are dropped.
REQ-008 REDIRECT: FLUSH=1, JMP_DO=1, JMP_PC=jmp_pc; ->SETTLE unless MMU_WAIT=1 (then hold, outputs unchanged).
REQ-009 SETTLE: FLUSH=1, JMP_DO=0; TRAP_EN/MRET_EN/CHMODE_DO/CSR_W_EN ignored; ->IDLE unless MMU_WAIT=1.
REQ-010 Latency: trigger at cycle N -> JMP_DO high exactly in N+1 (no stall), FLUSH high N+1..N+2.
REQ-011 CSR_W_EN in IDLE, MMU_WAIT=0, no higher event: 0x341 mepc<=data & ~3; 0x342 mcause<=data; 0x300 MIE<=d[3], MPIE<=d[7], MPP<=d[12:11]; other addresses ignored.
REQ-012 CSR_W_EN outside IDLE or with MMU_WAIT=1 SHALL be dropped.
REQ-013 MSTATUS = {19'b0, MPP, 3'b0, MPIE, 3'b0, MIE, 3'b0}; all other bits read zero.
REQ-014 MPP write of 2'b10 SHALL store 2'b00 (reserved mode legalised).
REQ-015 IDLE with MMU_WAIT=1: no state or register updates.

Reset
REQ-016 RST=1 asynchronously: state IDLE, FLUSH=0, JMP_DO=0, JMP_PC=0, BUSY=0, MODE=RESET_MODE, MIE=0, MPIE=0, MPP=0, MEPC=0, MCAUSE=0.
REQ-017 RST during REDIRECT/SETTLE aborts redirect; no JMP_DO after release until a new trigger.

Structure
REQ-018 Shared package SHALL hold FSM state encoding, CSR addresses 0x300/0x341/0x342, mode constants U=00/S=01/M=11, mstatus bit positions.
REQ-019 Sub-module trap_csr_regs SHALL hold mepc/mcause/mstatus fields and write legalisation; FSM stays in trap_commit.

Verification
REQ-020 MODE=00, MIE=1; TRAP_EN, TRAP_PC=0x1002, TRAP_CODE=0x8000000B, TRAP_JMP_TO=0x100 -> N+1 JMP_DO=1, JMP_PC=0x100; MEPC=0x1000, MCAUSE=0x8000000B, MODE=11, MIE=0, MPIE=1, MPP=00; FLUSH N+1..N+2.
REQ-021 Following scenario 1, MRET_EN -> JMP_PC=0x1000, MODE=00, MIE=1, MPIE=1, MPP=00.
REQ-022 TRAP_EN, MRET_EN, CHMODE_DO, CSR_W_EN same cycle -> trap only; MODE=11, CSR unchanged.
REQ-023 MMU_WAIT=1 for 3 cycles while in REDIRECT -> JMP_DO held 4 cycles total, FLUSH 5, BUSY throughout.
REQ-024 CSR_W 0x300 data=0x1088 -> MSTATUS=0x0088 (MPP legalised 00); CSR_W 0x341 during SETTLE -> MEPC unchanged.
REQ-025 RST asserted mid-REDIRECT -> FLUSH/JMP_DO low immediately, MODE=11, all CSRs zero.

Source files
------------

// File: rtl/trap_commit_pkg.sv
// trap_commit_pkg: shared FSM encoding, CSR addresses, privilege modes and mstatus bit positions
package trap_commit_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SETTLE   = 2'd2
  } state_e;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;
  function automatic logic [1:0] legal_mpp(input logic [1:0] m);
    return (m == 2'b10) ? MODE_U : m;
  endfunction
endpackage

// File: rtl/trap_csr_regs.sv
// trap_csr_regs: mepc/mcause/mstatus storage with trap, mret and software-write updates
//   clk_i/rst_i: clock and async active-high reset
//   trap_i/mret_i/csr_we_i: mutually exclusive, already-qualified update strobes
//   csr_addr_i/csr_data_i: software write; trap_pc_i/trap_code_i/mode_i: trap entry data
//   mepc_o/mcause_o/mstatus_o/mie_o/mpie_o/mpp_o: register views
module trap_csr_regs
  import trap_commit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_data_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_code_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mstatus_o,
  output logic        mie_o,
  output logic        mpie_o,
  output logic [1:0]  mpp_o
);
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [1:0]  mpp_q, mpp_d;
  logic        wr_mepc, wr_mcause, wr_mstatus;
  assign wr_mepc    = csr_we_i && csr_addr_i == CSR_MEPC;
  assign wr_mcause  = csr_we_i && csr_addr_i == CSR_MCAUSE;
  assign wr_mstatus = csr_we_i && csr_addr_i == CSR_MSTATUS;
  always_comb begin
    mepc_d   = trap_i ? trap_pc_i & ~32'd3 : wr_mepc ? csr_data_i & ~32'd3 : mepc_q;
    mcause_d = trap_i ? trap_code_i : wr_mcause ? csr_data_i : mcause_q;
    mie_d    = trap_i ? 1'b0 : mret_i ? mpie_q : wr_mstatus ? csr_data_i[MSTATUS_MIE] : mie_q;
    mpie_d   = trap_i ? mie_q : mret_i ? 1'b1 : wr_mstatus ? csr_data_i[MSTATUS_MPIE] : mpie_q;
    mpp_d    = trap_i ? legal_mpp(mode_i) : mret_i ? MODE_U :
               wr_mstatus ? legal_mpp(csr_data_i[MSTATUS_MPP +: 2]) : mpp_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mpp_q    <= MODE_U;
    end else begin
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mpp_q    <= mpp_d;
    end
  end
  assign mepc_o    = mepc_q;
  assign mcause_o  = mcause_q;
  assign mie_o     = mie_q;
  assign mpie_o    = mpie_q;
  assign mpp_o     = mpp_q;
  assign mstatus_o = (32'(mpp_q) << MSTATUS_MPP) | (32'(mpie_q) << MSTATUS_MPIE) |
                     (32'(mie_q) << MSTATUS_MIE);
endmodule

// File: rtl/trap_commit.sv
// trap_commit: trap/mret commit FSM driving pipeline flush, fetch redirect and privilege mode
//   CLK/RST: clock, async active-high reset; MMU_WAIT: global stall
//   TRAP_*/MRET_EN/CHMODE_*/CSR_W_*: events, priority trap > mret > chmode > csr write
//   FLUSH/JMP_DO/JMP_PC/BUSY: redirect interface, registered only
//   MODE/INT_ALLOW/MEPC/MCAUSE/MSTATUS: architectural state views
module trap_commit
  import trap_commit_pkg::*;
#(
  parameter logic [1:0] RESET_MODE = 2'b11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MMU_WAIT,
  input  logic        TRAP_EN,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_CODE,
  input  logic [31:0] TRAP_JMP_TO,
  input  logic        CHMODE_DO,
  input  logic [1:0]  CHMODE_TO,
  input  logic        MRET_EN,
  input  logic        CSR_W_EN,
  input  logic [11:0] CSR_W_ADDR,
  input  logic [31:0] CSR_W_DATA,
  output logic        FLUSH,
  output logic        JMP_DO,
  output logic [31:0] JMP_PC,
  output logic [1:0]  MODE,
  output logic        INT_ALLOW,
  output logic [31:0] MEPC,
  output logic [31:0] MCAUSE,
  output logic [31:0] MSTATUS,
  output logic        BUSY
);
  state_e      state_q, state_d;
  logic [31:0] jmp_pc_q, jmp_pc_d;
  logic [1:0]  mode_q, mode_d;
  logic        idle_go, take_trap, take_mret, take_chmode, take_csr;
  logic        mpie;
  logic [1:0]  mpp;
  // Events are only accepted in IDLE without stall; lower-priority ones are dropped.
  assign idle_go     = state_q == ST_IDLE && !MMU_WAIT;
  assign take_trap   = idle_go && TRAP_EN;
  assign take_mret   = idle_go && !TRAP_EN && MRET_EN;
  assign take_chmode = idle_go && !TRAP_EN && !MRET_EN && CHMODE_DO;
  assign take_csr    = idle_go && !TRAP_EN && !MRET_EN && !CHMODE_DO && CSR_W_EN;
  trap_csr_regs u_csr (
    .clk_i       (CLK),
    .rst_i       (RST),
    .trap_i      (take_trap),
    .mret_i      (take_mret),
    .csr_we_i    (take_csr),
    .csr_addr_i  (CSR_W_ADDR),
    .csr_data_i  (CSR_W_DATA),
    .trap_pc_i   (TRAP_PC),
    .trap_code_i (TRAP_CODE),
    .mode_i      (mode_q),
    .mepc_o      (MEPC),
    .mcause_o    (MCAUSE),
    .mstatus_o   (MSTATUS),
    .mie_o       (INT_ALLOW),
    .mpie_o      (mpie),
    .mpp_o       (mpp)
  );
  always_comb begin
    state_d  = state_q;
    jmp_pc_d = take_trap ? TRAP_JMP_TO : take_mret ? MEPC : jmp_pc_q;
    mode_d   = take_trap ? MODE_M : take_mret ? mpp : take_chmode ? CHMODE_TO : mode_q;
    case (state_q)
      ST_IDLE:     state_d = (take_trap || take_mret) ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: state_d = MMU_WAIT ? ST_REDIRECT : ST_SETTLE;
      ST_SETTLE:   state_d = MMU_WAIT ? ST_SETTLE : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      jmp_pc_q <= '0;
      mode_q   <= RESET_MODE;
    end else begin
      state_q  <= state_d;
      jmp_pc_q <= jmp_pc_d;
      mode_q   <= mode_d;
    end
  end
  assign FLUSH  = state_q != ST_IDLE;
  assign BUSY   = state_q != ST_IDLE;
  assign JMP_DO = state_q == ST_REDIRECT;
  assign JMP_PC = jmp_pc_q;
  assign MODE   = mode_q;
  wire unused_mpie = mpie;
endmodule

// File: tb/tb_trap_commit.sv
// tb_trap_commit: directed and randomized checks of trap_commit against a behavioural model
module tb_trap_commit;
  logic        CLK = 0, RST = 1, MMU_WAIT = 0, TRAP_EN = 0, CHMODE_DO = 0, MRET_EN = 0, CSR_W_EN = 0;
  logic [31:0] TRAP_PC = 0, TRAP_CODE = 0, TRAP_JMP_TO = 0, CSR_W_DATA = 0;
  logic [1:0]  CHMODE_TO = 0;
  logic [11:0] CSR_W_ADDR = 0;
  logic        FLUSH, JMP_DO, INT_ALLOW, BUSY;
  logic [31:0] JMP_PC, MEPC, MCAUSE, MSTATUS;
  logic [1:0]  MODE;
  int checks = 0, errors = 0;
  int left;
  logic [1:0]  m_mode, m_mpp;
  logic        m_mie, m_mpie;
  logic [31:0] m_mepc, m_mcause, m_jpc;
  trap_commit dut (
    .CLK(CLK), .RST(RST), .MMU_WAIT(MMU_WAIT), .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC),
    .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .CHMODE_DO(CHMODE_DO),
    .CHMODE_TO(CHMODE_TO), .MRET_EN(MRET_EN), .CSR_W_EN(CSR_W_EN), .CSR_W_ADDR(CSR_W_ADDR),
    .CSR_W_DATA(CSR_W_DATA), .FLUSH(FLUSH), .JMP_DO(JMP_DO), .JMP_PC(JMP_PC), .MODE(MODE),
    .INT_ALLOW(INT_ALLOW), .MEPC(MEPC), .MCAUSE(MCAUSE), .MSTATUS(MSTATUS), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] legal(input logic [1:0] m);
    return m == 2'b10 ? 2'b00 : m;
  endfunction
  task automatic model_reset();
    left = 0; m_mode = 2'b11; m_mpp = 0; m_mie = 0; m_mpie = 0;
    m_mepc = 0; m_mcause = 0; m_jpc = 0;
  endtask
  // Model: `left` counts remaining flush cycles; the first of the two also carries the jump.
  task automatic model_step();
    if (MMU_WAIT) return;
    if (left > 0) begin
      left--;
      return;
    end
    if (TRAP_EN) begin
      m_mepc = TRAP_PC & ~32'd3; m_mcause = TRAP_CODE; m_mpie = m_mie; m_mie = 0;
      m_mpp = legal(m_mode); m_mode = 2'b11; m_jpc = TRAP_JMP_TO; left = 2;
    end else if (MRET_EN) begin
      m_jpc = m_mepc; m_mode = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 0; left = 2;
    end else if (CHMODE_DO) m_mode = CHMODE_TO;
    else if (CSR_W_EN) begin
      if (CSR_W_ADDR == 12'h341) m_mepc = CSR_W_DATA & ~32'd3;
      else if (CSR_W_ADDR == 12'h342) m_mcause = CSR_W_DATA;
      else if (CSR_W_ADDR == 12'h300) begin
        m_mie = CSR_W_DATA[3]; m_mpie = CSR_W_DATA[7]; m_mpp = legal(CSR_W_DATA[12:11]);
      end
    end
  endtask
  task automatic check_all(input string s);
    check({s, "_flush"}, 32'(FLUSH), 32'(left > 0));
    check({s, "_busy"}, 32'(BUSY), 32'(left > 0));
    check({s, "_jmp_do"}, 32'(JMP_DO), 32'(left == 2));
    check({s, "_jmp_pc"}, JMP_PC, m_jpc);
    check({s, "_mode"}, 32'(MODE), 32'(m_mode));
    check({s, "_mepc"}, MEPC, m_mepc);
    check({s, "_mcause"}, MCAUSE, m_mcause);
    check({s, "_mstatus"}, MSTATUS, {19'b0, m_mpp, 3'b0, m_mpie, 3'b0, m_mie, 3'b0});
    check({s, "_int_allow"}, 32'(INT_ALLOW), 32'(m_mie));
  endtask
  task automatic idle_inputs();
    MMU_WAIT = 0; TRAP_EN = 0; MRET_EN = 0; CHMODE_DO = 0; CSR_W_EN = 0;
  endtask
  // Inputs are set at the falling edge, the model advances with the rising edge,
  // and outputs are compared at the next falling edge.
  task automatic cycle(input string s);
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_all(s);
    idle_inputs();
  endtask
  int jcnt, fcnt;
  initial begin
    model_reset();
    @(negedge CLK);
    check_all("reset");
    RST = 0;
    cycle("idle0");
    CHMODE_DO = 1; CHMODE_TO = 2'b00; cycle("chmode_u");
    CSR_W_EN = 1; CSR_W_ADDR = 12'h300; CSR_W_DATA = 32'h8; cycle("set_mie");
    TRAP_EN = 1; TRAP_PC = 32'h1002; TRAP_CODE = 32'h8000000B; TRAP_JMP_TO = 32'h100;
    cycle("s1_n1");
    check("s1_jmp_do", 32'(JMP_DO), 1); check("s1_jmp_pc", JMP_PC, 32'h100);
    check("s1_mepc", MEPC, 32'h1000); check("s1_mstatus", MSTATUS, 32'h80);
    check("s1_mode", 32'(MODE), 3);
    cycle("s1_n2");
    check("s1_flush_n2", 32'(FLUSH), 1); check("s1_jmp_do_n2", 32'(JMP_DO), 0);
    cycle("s1_n3");
    check("s1_flush_n3", 32'(FLUSH), 0);
    MRET_EN = 1; cycle("s2_mret");
    check("s2_jmp_pc", JMP_PC, 32'h1000); check("s2_mode", 32'(MODE), 0);
    check("s2_mstatus", MSTATUS, 32'h88);
    cycle("s2_settle"); cycle("s2_idle");
    TRAP_EN = 1; MRET_EN = 1; CHMODE_DO = 1; CHMODE_TO = 2'b01; CSR_W_EN = 1;
    CSR_W_ADDR = 12'h342; CSR_W_DATA = 32'h55; TRAP_CODE = 32'h7; TRAP_PC = 32'h2000;
    TRAP_JMP_TO = 32'h200;
    cycle("s3_all");
    check("s3_mode", 32'(MODE), 3); check("s3_mcause", MCAUSE, 32'h7);
    jcnt = 32'(JMP_DO); fcnt = 32'(FLUSH);
    for (int i = 0; i < 3; i++) begin
      MMU_WAIT = 1; cycle("s4_wait");
      jcnt += 32'(JMP_DO); fcnt += 32'(FLUSH);
      check("s4_busy", 32'(BUSY), 1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle("s4_run"); jcnt += 32'(JMP_DO); fcnt += 32'(FLUSH);
    end
    check("s4_jmp_cycles", 32'(jcnt), 4); check("s4_flush_cycles", 32'(fcnt), 5);
    CSR_W_EN = 1; CSR_W_ADDR = 12'h300; CSR_W_DATA = 32'h1088; cycle("s5_mstatus");
    check("s5_mstatus", MSTATUS, 32'h88);
    TRAP_EN = 1; TRAP_PC = 32'h3004; cycle("s5_trap");
    CSR_W_EN = 1; CSR_W_ADDR = 12'h341; CSR_W_DATA = 32'hABC0; cycle("s5_redirect_wr");
    CSR_W_EN = 1; CSR_W_ADDR = 12'h341; CSR_W_DATA = 32'hABC0; cycle("s5_settle_wr");
    check("s5_mepc", MEPC, 32'h3004);
    TRAP_EN = 1; TRAP_PC = 32'h44; cycle("s6_trap");
    #2 RST = 1; #1;
    model_reset();
    check("s6_flush", 32'(FLUSH), 0); check("s6_jmp_do", 32'(JMP_DO), 0);
    check("s6_mode", 32'(MODE), 3); check("s6_mepc", MEPC, 0);
    check("s6_mcause", MCAUSE, 0); check("s6_mstatus", MSTATUS, 0);
    @(negedge CLK); RST = 0;
    cycle("s6_after1"); cycle("s6_after2");
    for (int i = 0; i < 3000; i++) begin
      MMU_WAIT = ($urandom_range(0, 4) == 0);
      TRAP_EN = ($urandom_range(0, 9) == 0);
      MRET_EN = ($urandom_range(0, 7) == 0);
      CHMODE_DO = ($urandom_range(0, 5) == 0);
      CSR_W_EN = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: CHMODE_TO = 2'b00;
        1: CHMODE_TO = 2'b01;
        default: CHMODE_TO = 2'b11;
      endcase
      case ($urandom_range(0, 3))
        0: CSR_W_ADDR = 12'h300;
        1: CSR_W_ADDR = 12'h341;
        2: CSR_W_ADDR = 12'h342;
        default: CSR_W_ADDR = 12'($urandom);
      endcase
      CSR_W_DATA = $urandom; TRAP_PC = $urandom; TRAP_CODE = $urandom; TRAP_JMP_TO = $urandom;
      cycle("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
